uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the shared transmitter arbiter.
// master = environment (requesters + uart_tx), slave = the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   send_in;
  logic [8*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   busy_out;
  logic [7:0]           tx_data;
  logic                 tx_send;
  logic                 tx_busy;
  logic                 timeout_flag;

  modport master (
    output req, send_in, data_in, tx_busy,
    input  grant, busy_out, tx_data, tx_send, timeout_flag
  );

  modport slave (
    input  req, send_in, data_in, tx_busy,
    output grant, busy_out, tx_data, tx_send, timeout_flag
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ burst requesters.
// Optional idle-owner timeout with lockout is enabled by defining TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      winner;
  logic               win_vld;
  logic               sent_q;
  logic               tx_send;
  logic [7:0]         tx_data;
  logic               owner_req, owner_send;
  logic [7:0]         owner_data;
  logic [NUM_REQ-1:0] eligible;
  logic               force_rel;
  int unsigned        idx;

  // Owner's request lines, muxed with constant indices
  always_comb begin
    owner_req  = 1'b0;
    owner_send = 1'b0;
    owner_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_req  = bus.req[i];
        owner_send = bus.send_in[i];
        owner_data = bus.data_in[8*i +: 8];
      end
    end
  end

  // Descending scan so the smallest offset from ptr wins
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = 32'(ptr_q) + 32'(k);
      if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
      if (eligible[idx]) begin
        winner  = IW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    tx_send = 1'b0;
    tx_data = 8'h00;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d         = GRANT;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          ptr_d           = (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end
      end
      GRANT: begin
        tx_send = owner_req & owner_send & ~bus.tx_busy & ~sent_q;
        tx_data = owner_data;
        if (!owner_req || force_rel) begin
          state_d = DRAIN;
          grant_d = '0;
        end
      end
      DRAIN: begin
        if (!bus.tx_busy && !sent_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sent_q  <= tx_send;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] lockout_q;
  logic               flag_q;
  logic               idle_g;

  assign idle_g    = (state_q == GRANT) & owner_req & ~tx_send & ~bus.tx_busy & ~sent_q;
  assign force_rel = idle_g && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign eligible  = bus.req & ~lockout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      lockout_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      if (state_q != GRANT || tx_send || force_rel) cnt_q <= '0;
      else if (idle_g)                              cnt_q <= cnt_q + 1'b1;
      // A low req clears lockout; a forced release in the same cycle wins
      lockout_q <= lockout_q & bus.req;
      if (force_rel) begin
        lockout_q[owner_q] <= 1'b1;
        flag_q             <= 1'b1;
      end
    end
  end

  assign bus.timeout_flag = flag_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign force_rel          = 1'b0;
  assign eligible           = bus.req;
  assign bus.timeout_flag   = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      bus.busy_out[i] = grant_q[i] ? (bus.tx_busy | sent_q) : 1'b1;
  end

  assign bus.grant   = grant_q;
  assign bus.tx_send = tx_send;
  assign bus.tx_data = tx_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=3); the timeout scenario runs
// when TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req     = '0;
    bus.send_in = '0;
    bus.data_in = '0;
    bus.tx_busy = 1'b0;
    step();
    step();
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy_out", 32'(bus.busy_out), 32'h7);
    chk("rst_tx_send", 32'(bus.tx_send), 32'h0);
    chk("rst_flag", 32'(bus.timeout_flag), 32'h0);

    // Round-robin from ptr=0: 1 wins over 2, then 2 after release
    rst = 1'b0;
    bus.req = 3'b110;
    step(); #1;
    chk("rr_grant1", 32'(bus.grant), 32'h2);
    chk("rr_busy_out", 32'(bus.busy_out), 32'h5);
    bus.req = 3'b100;
    step(); #1;
    chk("rel_grant0", 32'(bus.grant), 32'h0);
    step(); #1;
    chk("idle_grant0", 32'(bus.grant), 32'h0);
    step(); #1;
    chk("rr_grant2", 32'(bus.grant), 32'h4);

    bus.req = 3'b000;
    step();
    step();
    bus.req = 3'b001;
    step(); #1;
    chk("grant0", 32'(bus.grant), 32'h1);

    // Owner 0 sends 0x35
    bus.send_in = 3'b001;
    bus.data_in[7:0] = 8'h35;
    #1;
    chk("send_strobe", 32'(bus.tx_send), 32'h1);
    chk("send_data", 32'(bus.tx_data), 32'h35);
    step();
    bus.send_in = 3'b000;
    #1;
    chk("sent_q_busy", 32'(bus.busy_out), 32'h7);
    bus.tx_busy = 1'b1;
    bus.send_in = 3'b001;
    bus.data_in[7:0] = 8'h36;
    #1;
    chk("send_while_busy", 32'(bus.tx_send), 32'h0);
    step();
    bus.send_in = 3'b000;
    bus.tx_busy = 1'b0;

    // Non-owner strobe is ignored
    bus.send_in = 3'b010;
    bus.data_in[15:8] = 8'hAA;
    bus.data_in[7:0]  = 8'h11;
    #1;
    chk("nonowner_send", 32'(bus.tx_send), 32'h0);
    chk("nonowner_data", 32'(bus.tx_data), 32'h11);
    step(); #1;
    chk("nonowner_send2", 32'(bus.tx_send), 32'h0);

    // req drop together with send_in: byte dropped
    bus.send_in = 3'b001;
    bus.req     = 3'b000;
    #1;
    chk("drop_same_cycle", 32'(bus.tx_send), 32'h0);
    step();
    bus.send_in = 3'b000;
    #1;
    chk("drain_grant", 32'(bus.grant), 32'h0);
    chk("drain_data", 32'(bus.tx_data), 32'h0);
    step();

    // Long drain: owner 0 releases while uart_tx busy for 50 cycles
    bus.req = 3'b001;
    step(); #1;
    chk("grant0_b", 32'(bus.grant), 32'h1);
    bus.send_in = 3'b001;
    bus.data_in[7:0] = 8'h5A;
    #1;
    chk("send_5a", 32'(bus.tx_send), 32'h1);
    step();
    bus.send_in = 3'b000;
    bus.tx_busy = 1'b1;
    bus.req     = 3'b100;
    step(); #1;
    chk("drain_start", 32'(bus.grant), 32'h0);
    for (int i = 0; i < 48; i++) begin
      step(); #1;
      chk("drain_hold", 32'(bus.grant), 32'h0);
    end
    chk("drain_busy_out", 32'(bus.busy_out), 32'h7);
    step();
    bus.tx_busy = 1'b0;
    step(); #1;
    chk("drain_to_idle", 32'(bus.grant), 32'h0);
    step(); #1;
    chk("grant2_after_drain", 32'(bus.grant), 32'h4);

    // Reset mid-burst with ptr=1 must return ptr to 0
    bus.req = 3'b000;
    step();
    step();
    bus.req = 3'b001;
    step(); #1;
    chk("grant0_c", 32'(bus.grant), 32'h1);
    bus.tx_busy = 1'b1;
    bus.send_in = 3'b001;
    bus.req     = 3'b101;
    rst = 1'b1;
    step(); #1;
    chk("midrst_grant", 32'(bus.grant), 32'h0);
    chk("midrst_send", 32'(bus.tx_send), 32'h0);
    chk("midrst_busy_out", 32'(bus.busy_out), 32'h7);
    rst = 1'b0;
    bus.send_in = 3'b000;
    bus.tx_busy = 1'b0;
    step(); #1;
    chk("ptr_reset_grant", 32'(bus.grant), 32'h1);

`ifdef TX_ARB_TIMEOUT_EN
    bus.req = 3'b000;
    step();
    step();
    bus.req = 3'b010;
    step(); #1;
    chk("to_grant", 32'(bus.grant), 32'h2);
    for (int i = 0; i < 15; i++) step();
    #1;
    chk("to_hold15", 32'(bus.grant), 32'h2);
    chk("to_flag_pre", 32'(bus.timeout_flag), 32'h0);
    step(); #1;
    chk("to_release", 32'(bus.grant), 32'h0);
    chk("to_flag", 32'(bus.timeout_flag), 32'h1);
    step();
    step();
    step(); #1;
    chk("lockout_hold", 32'(bus.grant), 32'h0);
    bus.req = 3'b000;
    step();
    bus.req = 3'b010;
    step(); #1;
    chk("lockout_cleared", 32'(bus.grant), 32'h2);
`else
    bus.req = 3'b001;
    for (int i = 0; i < 20; i++) step();
    #1;
    chk("no_timeout_grant", 32'(bus.grant), 32'h1);
    chk("no_timeout_flag", 32'(bus.timeout_flag), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
